// File: rtl/arb_requester.sv
// arb_requester: client-side agent for a two-port req/gnt arbiter.
// Each channel queues job pulses, requests the bus, holds it for a fixed
// burst once granted, then releases it for one cycle. Starvation, pending
// overflow and grant protocol violations are reported through sticky flags.

module arb_requester_chan #(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              job,
  input  logic              gnt,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pend,
  output logic              starve,
  output logic              ovf,
  output logic              abort
);

  // State encoding keeps req equal to bit 0, so req comes straight off a flop.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_XFER = 2'b11;
  localparam logic [1:0] ST_REL  = 2'b10;

  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  WAIT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = {PEND_W{1'b1}};

  logic [1:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             complete;

  // The last granted beat of a burst retires the in-flight job.
  assign complete = (state == ST_XFER) && gnt && (beat_cnt == BEAT_LAST);

  // Losing the grant before the burst ends aborts it and retries the job.
  assign abort = (state == ST_XFER) && !gnt;

  assign req  = state[0];
  assign busy = (state == ST_XFER);

  // Request/transfer/release sequencing with beat and wait counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= complete;
      case (state)
        ST_IDLE: begin
          if (pend != '0) begin
            state    <= ST_REQ;
            wait_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (gnt) begin
            state    <= ST_XFER;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (!gnt) begin
            state    <= ST_REQ;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end else if (beat_cnt == BEAT_LAST) begin
            state    <= ST_REL;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_REL: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Set the starvation flag on the cycle the wait counter reaches the timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve <= 1'b0;
    end else if ((state == ST_REQ) && !gnt && (wait_cnt == WAIT_LAST)) begin
      starve <= 1'b1;
    end
  end

  // Pending job count: a job arriving with a completion is always accepted,
  // a job arriving at a full counter without a completion is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else if (job && !complete) begin
      if (pend == PEND_FULL) begin
        ovf <= 1'b1;
      end else begin
        pend <= pend + 1'b1;
      end
    end else if (complete && !job && (pend != '0)) begin
      pend <= pend - 1'b1;
    end
  end

endmodule

module arb_requester #(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              job_0,
  input  logic              job_1,
  input  logic              gnt_0,
  input  logic              gnt_1,
  output logic              req_0,
  output logic              req_1,
  output logic              busy_0,
  output logic              busy_1,
  output logic              done_0,
  output logic              done_1,
  output logic [PEND_W-1:0] pend_0,
  output logic [PEND_W-1:0] pend_1,
  output logic              starve_0,
  output logic              starve_1,
  output logic              ovf_0,
  output logic              ovf_1,
  output logic              proto_err
);

  logic abort_0;
  logic abort_1;

  arb_requester_chan #(
    .BURST_LEN (BURST_LEN),
    .PEND_W    (PEND_W),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_chan_0 (
    .clock  (clock),
    .reset  (reset),
    .job    (job_0),
    .gnt    (gnt_0),
    .req    (req_0),
    .busy   (busy_0),
    .done   (done_0),
    .pend   (pend_0),
    .starve (starve_0),
    .ovf    (ovf_0),
    .abort  (abort_0)
  );

  arb_requester_chan #(
    .BURST_LEN (BURST_LEN),
    .PEND_W    (PEND_W),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_chan_1 (
    .clock  (clock),
    .reset  (reset),
    .job    (job_1),
    .gnt    (gnt_1),
    .req    (req_1),
    .busy   (busy_1),
    .done   (done_1),
    .pend   (pend_1),
    .starve (starve_1),
    .ovf    (ovf_1),
    .abort  (abort_1)
  );

  // Latch any grant protocol violation: overlapping grants or a grant lost mid-burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if ((gnt_0 && gnt_1) || abort_0 || abort_1) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed stimulus for arb_requester with a burst
// scoreboard; a negedge monitor pops expected bursts on every done pulse.
`timescale 1ns/1ps

module tb_arb_requester;

  localparam int BURST_LEN = 4;
  localparam int PEND_W    = 3;
  localparam int TIMEOUT   = 15;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [PEND_W-1:0] pend;
    logic [7:0]        beats;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              job_0 = 1'b0;
  logic              job_1 = 1'b0;
  logic              gnt_0;
  logic              gnt_1;
  logic              req_0, req_1, busy_0, busy_1, done_0, done_1;
  logic [PEND_W-1:0] pend_0, pend_1;
  logic              starve_0, starve_1, ovf_0, ovf_1, proto_err;

  logic [1:0] mode_0 = 2'd0;
  logic [1:0] mode_1 = 2'd0;
  logic       man_gnt_0 = 1'b0;
  logic       man_gnt_1 = 1'b0;
  logic       reg_gnt_0 = 1'b0;
  logic       reg_gnt_1 = 1'b0;

  exp_t sb_0[$];
  exp_t sb_1[$];
  int   checks = 0;
  int   errors = 0;
  int   run_0 = 0;
  int   run_1 = 0;

  arb_requester #(
    .BURST_LEN (BURST_LEN),
    .PEND_W    (PEND_W),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .job_0     (job_0),
    .job_1     (job_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .req_0     (req_0),
    .req_1     (req_1),
    .busy_0    (busy_0),
    .busy_1    (busy_1),
    .done_0    (done_0),
    .done_1    (done_1),
    .pend_0    (pend_0),
    .pend_1    (pend_1),
    .starve_0  (starve_0),
    .starve_1  (starve_1),
    .ovf_0     (ovf_0),
    .ovf_1     (ovf_1),
    .proto_err (proto_err)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Arbiter model: mode 0 manual, mode 1 grant one cycle after req, mode 2 grant follows req.
  always @(posedge clock) begin
    reg_gnt_0 <= req_0;
    reg_gnt_1 <= req_1;
  end

  assign gnt_0 = (mode_0 == 2'd2) ? req_0 : (mode_0 == 2'd1) ? reg_gnt_0 : man_gnt_0;
  assign gnt_1 = (mode_1 == 2'd2) ? req_1 : (mode_1 == 2'd1) ? reg_gnt_1 : man_gnt_1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic j0, input logic j1, input int cycles);
    job_0 = j0;
    job_1 = j1;
    repeat (cycles) step();
    job_0 = 1'b0;
    job_1 = 1'b0;
  endtask

  task automatic scoreBurst(input int ch, input int run, input logic [PEND_W-1:0] pend_now);
    exp_t e;
    if ((ch == 0 && sb_0.size() == 0) || (ch == 1 && sb_1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected done on ch%0d: got done, expected none", ch);
    end else begin
      e = (ch == 0) ? sb_0.pop_front() : sb_1.pop_front();
      checkOutput($sformatf("ch%0d burst length", ch), run, {24'd0, e.beats});
      checkOutput($sformatf("ch%0d pend after done", ch), {29'd0, pend_now}, {29'd0, e.pend});
    end
  endtask

  task automatic waitDone(input int ch, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if ((ch == 0 && done_0) || (ch == 1 && done_1)) seen = 1'b1;
    end
    checkOutput($sformatf("ch%0d done within budget", ch), {31'd0, seen}, 32'd1);
  endtask

  function automatic logic [31:0] allOutputs();
    return {18'd0, req_0, req_1, busy_0, busy_1, done_0, done_1,
            pend_0, pend_1, starve_0, starve_1, ovf_0, ovf_1, proto_err};
  endfunction

  // Monitor: measure busy run length and score each completed burst at its done pulse.
  always @(negedge clock) begin
    if (busy_0) run_0++;
    else begin
      if (done_0) scoreBurst(0, run_0, pend_0);
      run_0 = 0;
    end
    if (busy_1) run_1++;
    else begin
      if (done_1) scoreBurst(1, run_1, pend_1);
      run_1 = 0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two cycles
    step();
    step();
    checkOutput("reset state", allOutputs(), 32'd0);
    reset = 1'b0;

    // Single job on channel 0, registered grant
    mode_0 = 2'd1;
    sb_0.push_back('{pend: 3'd0, beats: 8'd4});
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("ch0 pend after job", {29'd0, pend_0}, 32'd1);
    checkOutput("ch0 req one edge after job", {31'd0, req_0}, 32'd0);
    step();
    checkOutput("ch0 req two edges after job", {31'd0, req_0}, 32'd1);
    waitDone(0, 20);
    checkOutput("ch0 req released at done", {31'd0, req_0}, 32'd0);
    step();
    checkOutput("ch0 done single cycle", {31'd0, done_0}, 32'd0);
    mode_0 = 2'd0;
    man_gnt_0 = 1'b0;
    step();

    // Three jobs on channel 1 with grant following req
    mode_1 = 2'd2;
    sb_1.push_back('{pend: 3'd2, beats: 8'd4});
    sb_1.push_back('{pend: 3'd1, beats: 8'd4});
    sb_1.push_back('{pend: 3'd0, beats: 8'd4});
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("ch1 pend after three jobs", {29'd0, pend_1}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      waitDone(1, 20);
      if (k < 2) begin
        step();
        checkOutput("ch1 req low in idle gap", {31'd0, req_1}, 32'd0);
        step();
        checkOutput("ch1 req back after gap", {31'd0, req_1}, 32'd1);
      end
    end
    mode_1 = 2'd0;
    man_gnt_1 = 1'b0;
    step();
    step();

    // Eight jobs on channel 0 with no grant: overflow then starvation
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("ch0 pend saturates", {29'd0, pend_0}, 32'd7);
    checkOutput("ch0 ovf set", {31'd0, ovf_0}, 32'd1);
    checkOutput("ch0 req held", {31'd0, req_0}, 32'd1);
    checkOutput("ch0 starve early", {31'd0, starve_0}, 32'd0);
    repeat (8) step();
    checkOutput("ch0 starve before timeout", {31'd0, starve_0}, 32'd0);
    step();
    checkOutput("ch0 starve at timeout", {31'd0, starve_0}, 32'd1);
    checkOutput("ch0 req held while starving", {31'd0, req_0}, 32'd1);
    checkOutput("ch1 flags untouched", {30'd0, starve_1, ovf_1}, 32'd0);

    // Grant dropped after two beats aborts the burst
    man_gnt_0 = 1'b1;
    step();
    checkOutput("ch0 busy after grant", {31'd0, busy_0}, 32'd1);
    step();
    step();
    checkOutput("proto_err before drop", {31'd0, proto_err}, 32'd0);
    man_gnt_0 = 1'b0;
    step();
    checkOutput("proto_err after drop", {31'd0, proto_err}, 32'd1);
    checkOutput("ch0 back in req after abort", {30'd0, req_0, busy_0}, 32'd2);
    checkOutput("ch0 pend kept after abort", {29'd0, pend_0}, 32'd7);
    sb_0.push_back('{pend: 3'd6, beats: 8'd4});
    man_gnt_0 = 1'b1;
    waitDone(0, 20);
    man_gnt_0 = 1'b0;
    checkOutput("ch0 sticky flags kept", {30'd0, starve_0, ovf_0}, 32'd3);

    // Reset clears everything including sticky flags
    reset = 1'b1;
    step();
    checkOutput("reset clears all", allOutputs(), 32'd0);
    step();
    reset = 1'b0;

    // Job coincident with completion at a full counter
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("ch0 pend full", {29'd0, pend_0}, 32'd7);
    checkOutput("ch0 no ovf at full", {31'd0, ovf_0}, 32'd0);
    sb_0.push_back('{pend: 3'd7, beats: 8'd4});
    man_gnt_0 = 1'b1;
    repeat (4) step();
    job_0 = 1'b1;
    step();
    job_0 = 1'b0;
    checkOutput("ch0 done with coincident job", {31'd0, done_0}, 32'd1);
    checkOutput("ch0 pend unchanged", {29'd0, pend_0}, 32'd7);
    checkOutput("ch0 ovf still clear", {31'd0, ovf_0}, 32'd0);
    man_gnt_0 = 1'b0;

    // Overlapping grants, then reset mid-burst
    applyStimulus(1'b0, 1'b1, 1);
    step();
    checkOutput("both channels requesting", {30'd0, req_0, req_1}, 32'd3);
    checkOutput("proto_err clear before overlap", {31'd0, proto_err}, 32'd0);
    man_gnt_0 = 1'b1;
    man_gnt_1 = 1'b1;
    step();
    checkOutput("proto_err on overlapping grants", {31'd0, proto_err}, 32'd1);
    man_gnt_1 = 1'b0;
    step();
    checkOutput("ch0 mid-burst", {31'd0, busy_0}, 32'd1);
    reset = 1'b1;
    step();
    checkOutput("reset mid-burst clears all", allOutputs(), 32'd0);
    reset = 1'b0;
    man_gnt_0 = 1'b0;
    step();
    step();
    checkOutput("job discarded after reset", {30'd0, req_0, (pend_0 != 0)}, 32'd0);

    checkOutput("ch0 scoreboard drained", sb_0.size(), 32'd0);
    checkOutput("ch1 scoreboard drained", sb_1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side agent for the two-port req/gnt arbiter: drives req_0/req_1 and consumes gnt_0/gnt_1.
- Each channel queues job pulses in a pending counter. It requests the bus, holds req through a fixed-length burst once granted, then releases for one cycle.
- Flags starvation, overflow and grant-protocol violations. Used as the traffic source in front of the arbiter and as a bus master model in system benches.

Parameters:
- BURST_LEN, 4, cycles a channel holds the bus per job (1..2^CNT_W-1).
- PEND_W, 3, width of each pending-job counter (max 2^PEND_W-1 jobs queued).
- TIMEOUT, 15, cycles of unanswered req before starve flag sets (1..2^CNT_W-1).
- CNT_W, 4, width of the beat and wait counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- job_0  in  1  enqueue one job on channel 0 (one per cycle when high).
- job_1  in  1  enqueue one job on channel 1.
- gnt_0  in  1  grant from arbiter to channel 0.
- gnt_1  in  1  grant from arbiter to channel 1.
- req_0  out  1  bus request, channel 0 (registered).
- req_1  out  1  bus request, channel 1 (registered).
- busy_0 / busy_1  out  1  channel is in a burst (XFER state).
- done_0 / done_1  out  1  one-cycle pulse when a burst completes.
- pend_0 / pend_1  out  PEND_W  jobs queued, including the one in flight.
- starve_0 / starve_1  out  1  sticky: req waited TIMEOUT cycles without gnt.
- ovf_0 / ovf_1  out  1  sticky: job dropped because the pending counter was full.
- proto_err  out  1  sticky: gnt_0 and gnt_1 were both high, or gnt dropped mid-burst.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 on the edge that samples reset high. Both FSMs go to IDLE and all counters clear.
  - Reset mid-burst: req drops after that edge and the job is discarded.
- FSMs: two identical, independent per-channel FSMs with states IDLE, REQ, XFER, REL.
  - req_x = 1 in REQ and XFER; busy_x = 1 in XFER only.
- IDLE: if pend_x != 0 -> REQ.
  - Latency: job_x sampled at edge E0 -> pend_x=1 after E0 -> req_x=1 after E1.
- REQ:
  - Wait counter increments each cycle while gnt_x=0.
  - Wait counter reaching TIMEOUT sets starve_x. The FSM stays in REQ and the wait counter saturates.
  - gnt_x sampled high -> XFER; beat counter and wait counter clear.
- XFER:
  - Beat counter increments each cycle with gnt_x=1.
  - After BURST_LEN XFER cycles -> REL, pend_x decrements, and done_x pulses for that one cycle.
  - gnt_x sampled low in XFER before the burst ends: proto_err sets, the burst aborts, and the FSM returns to REQ. pend_x is unchanged (job retried).
- REL:
  - req_x=0 for exactly one cycle, then -> IDLE.
  - gnt_x high during REL or IDLE is ignored (arbiter latency).
  - Back-to-back jobs therefore see req low for 2 cycles (REL + IDLE).
- Pending counter:
  - job only: +1.
  - completion only: -1.
  - job and completion in the same cycle: unchanged, and the job is accepted even when full.
  - job while full with no completion: dropped, ovf_x sets.
  - Never wraps.
- proto_err also sets on any cycle with gnt_0=gnt_1=1.
- Sticky flags clear only on reset.
- Channels never interact except through proto_err.

Test Plan:
- Reset held 2 cycles, then one job_0 pulse, gnt_0 returned 1 cycle after req_0 -> req_0 rises 2 edges after the job, busy_0 high 4 cycles, done_0 pulses once, pend_0 1->0, req_0 low.
- 3 job_1 pulses, gnt_1 tied high whenever req_1 -> three 4-cycle bursts separated by 2-cycle req gaps, pend_1 3->2->1->0, three done_1 pulses.
- 8 consecutive job_0 pulses with gnt_0=0 -> pend_0=7, ovf_0=1; req_0 held and starve_0=1 15 cycles after req_0 rises.
- gnt_0 dropped after 2 beats of a burst -> proto_err=1, FSM back in REQ, pend_0 unchanged; a later full grant completes with done_0.
- Both channels requesting and the bench drives gnt_0=gnt_1=1 for one cycle -> proto_err=1; reset asserted mid-burst -> all outputs 0 next edge.
- job_0 pulse coincident with burst completion at pend_0=7 -> pend_0 stays 7, ovf_0 stays 0.
